dut_cmd_sequencer: RTL

Control-plane sequencer for the DUT pipeline (fetch/decode/execute/writeback). It pops commands from the DI_FIFO, loads the output-mux and trigger-mask configuration registers, and runs stimulus batches by enabling the fetch stage for exactly N vectors. It then waits until N results have been written to RES_FIFO before it accepts the next command.

---
 rtl/dut_cmd_sequencer_if.sv | 32 +++
 rtl/dut_cmd_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dut_cmd_sequencer_if.sv
// dut_cmd_sequencer_if: DI_FIFO, fetch/result handshake and status signals of the command sequencer
interface dut_cmd_sequencer_if #(
    parameter int STF_WIDTH = 24,
    parameter int RTF_WIDTH = 24,
    parameter int REQ_WIDTH = 3,
    parameter int CMD_WIDTH = 5,
    parameter int CNT_WIDTH = 16,
    parameter int DIF_WIDTH = REQ_WIDTH + CMD_WIDTH + STF_WIDTH
);
    logic [DIF_WIDTH-1:0] dififo_data;
    logic                 dififo_rdreq;
    logic                 dififo_rdempty;
    logic                 stim_run;
    logic                 stim_rdreq;
    logic                 res_wrreq;
    logic [STF_WIDTH-1:0] mux_config_r;
    logic [RTF_WIDTH-1:0] trigger_mask_r;
    logic                 busy;
    logic                 done_r;
    logic                 err_r;
    logic [CNT_WIDTH-1:0] vec_count_r;

    modport master (
        input  dififo_data, dififo_rdempty, stim_rdreq, res_wrreq,
        output dififo_rdreq, stim_run, mux_config_r, trigger_mask_r, busy, done_r, err_r, vec_count_r
    );

    modport slave (
        output dififo_data, dififo_rdempty, stim_rdreq, res_wrreq,
        input  dififo_rdreq, stim_run, mux_config_r, trigger_mask_r, busy, done_r, err_r, vec_count_r
    );
endinterface

// File: rtl/dut_cmd_sequencer.sv
// dut_cmd_sequencer: pops DI_FIFO commands, loads mux/trigger config and runs N-vector batches; DUT_SEQ_TIMEOUT_EN adds a drain watchdog
module dut_cmd_sequencer #(
    parameter int STF_WIDTH      = 24,
    parameter int RTF_WIDTH      = 24,
    parameter int REQ_WIDTH      = 3,
    parameter int CMD_WIDTH      = 5,
    parameter int DIF_WIDTH      = REQ_WIDTH + CMD_WIDTH + STF_WIDTH,
`ifdef DUT_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    parameter int CNT_WIDTH      = 16
) (
    input logic                 clock,
    input logic                 reset,
    dut_cmd_sequencer_if.master bus
);
    localparam int CODE_WIDTH = REQ_WIDTH + CMD_WIDTH;
    localparam logic [CODE_WIDTH-1:0] C_NOP   = CODE_WIDTH'(8'h00);
    localparam logic [CODE_WIDTH-1:0] C_SETUP = CODE_WIDTH'(8'h01);
    localparam logic [CODE_WIDTH-1:0] C_TRG   = CODE_WIDTH'(8'h02);
    localparam logic [CODE_WIDTH-1:0] C_RUN   = CODE_WIDTH'(8'h03);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, DECODE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  n_r;
    logic [CNT_WIDTH-1:0]  issued_r;
    logic [CODE_WIDTH-1:0] code;
    logic [STF_WIDTH-1:0]  payload;
    logic [CNT_WIDTH-1:0]  batch_n;
    logic                  last_vec;
    logic [CNT_WIDTH-1:0]  issued_inc;
    logic [CNT_WIDTH-1:0]  vec_inc;

    assign code       = bus.dififo_data[DIF_WIDTH-1 -: CODE_WIDTH];
    assign payload    = bus.dififo_data[STF_WIDTH-1:0];
    assign batch_n    = payload[CNT_WIDTH-1:0];
    // the Nth pop drops stim_run in its own cycle so fetch never takes an extra vector
    assign last_vec   = bus.stim_rdreq && issued_r == n_r - CNT_ONE;
    assign issued_inc = (bus.stim_rdreq && issued_r != CNT_MAX) ? issued_r + CNT_ONE : issued_r;
    assign vec_inc    = (bus.res_wrreq && bus.vec_count_r != CNT_MAX) ? bus.vec_count_r + CNT_ONE : bus.vec_count_r;

    assign bus.dififo_rdreq = state == IDLE && !bus.dififo_rdempty && !reset;
    assign bus.stim_run     = state == RUN && !last_vec;
    assign bus.busy         = state != IDLE;

`ifdef DUT_SEQ_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_WIDTH-1:0] wd_r;
    logic                wd_expired;

    assign wd_expired = !bus.res_wrreq && wd_r == WD_WIDTH'(TIMEOUT_CYCLES - 1);

    // drain watchdog: restarts on every result, cleared while vectors are still being issued
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wd_r <= '0;
        else
            wd_r <= (state != DRAIN || bus.res_wrreq) ? '0 : wd_r + WD_WIDTH'(1);
    end
`else
    logic wd_expired;

    assign wd_expired = 1'b0;
`endif

    // command decode, batch control and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            n_r                <= '0;
            issued_r           <= '0;
            bus.vec_count_r    <= '0;
            bus.mux_config_r   <= '0;
            bus.trigger_mask_r <= '0;
            bus.done_r         <= 1'b0;
            bus.err_r          <= 1'b0;
        end else begin
            bus.done_r <= 1'b0;
            case (state)
                IDLE: if (!bus.dififo_rdempty) state <= DECODE;
                DECODE: begin
                    state <= IDLE;
                    if (code == C_SETUP)
                        bus.mux_config_r <= payload;
                    else if (code == C_TRG)
                        bus.trigger_mask_r <= payload[RTF_WIDTH-1:0];
                    else if (code == C_RUN) begin
                        n_r <= batch_n;
                        if (batch_n == '0) begin
                            state      <= DONE;
                            bus.done_r <= 1'b1;
                        end else begin
                            issued_r        <= '0;
                            bus.vec_count_r <= '0;
                            state           <= RUN;
                        end
                    end else if (code != C_NOP)
                        bus.err_r <= 1'b1;
                end
                RUN: begin
                    issued_r        <= issued_inc;
                    bus.vec_count_r <= vec_inc;
                    if (last_vec) state <= DRAIN;
                end
                DRAIN: begin
                    if (bus.vec_count_r == n_r) begin
                        state      <= DONE;
                        bus.done_r <= 1'b1;
                    end else if (wd_expired) begin
                        state      <= DONE;
                        bus.done_r <= 1'b1;
                        bus.err_r  <= 1'b1;
                    end else
                        bus.vec_count_r <= vec_inc;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
